// File: rtl/key_debounce.sv
// Push-button debouncer: 2-FF synchronizer, one-hot filter FSM, single-cycle press pulse.
// Optional auto-repeat while held is compiled in when KEY_REPEAT_EN is defined.
module key_debounce #(
    parameter int unsigned CNT_MAX    = 500_000,
    parameter logic        KEY_ACTIVE = 1'b0
`ifdef KEY_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DLY = 25_000_000,
    parameter int unsigned REPEAT_PER = 5_000_000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_flag,
    output logic key_state
);

    localparam int unsigned CW = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        IDLE      = 4'b0001,
        PRESS_FLT = 4'b0010,
        DOWN      = 4'b0100,
        REL_FLT   = 4'b1000
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          sync1, sync2;
    logic          key_p;
    logic          flag_nxt, level_nxt;
    logic          rep_hit;

    // Bring the asynchronous pin into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= ~KEY_ACTIVE;
            sync2 <= ~KEY_ACTIVE;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    assign key_p = (sync2 == KEY_ACTIVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            key_flag  <= 1'b0;
            key_state <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            key_flag  <= flag_nxt;
            key_state <= level_nxt;
        end
    end

    // Next-state, filter counter and registered-output values
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        flag_nxt  = 1'b0;
        level_nxt = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (key_p) state_nxt = PRESS_FLT;
            end
            PRESS_FLT: begin
                if (!key_p) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CW'(CNT_MAX - 1)) begin
                    state_nxt = DOWN;
                    cnt_nxt   = '0;
                    flag_nxt  = 1'b1;
                    level_nxt = 1'b1;
                end else if (cnt != CW'(CNT_MAX)) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DOWN: begin
                level_nxt = 1'b1;
                if (!key_p) begin
                    state_nxt = REL_FLT;
                    cnt_nxt   = '0;
                end else begin
                    flag_nxt = rep_hit;
                end
            end
            REL_FLT: begin
                level_nxt = 1'b1;
                if (key_p) begin
                    state_nxt = DOWN;
                    cnt_nxt   = '0;
                end else if (cnt == CW'(CNT_MAX - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                end else if (cnt != CW'(CNT_MAX)) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef KEY_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned RW      = $clog2(REP_MAX + 1);

    logic [RW-1:0] rep_cnt, rep_cnt_nxt;
    logic          rep_first, rep_first_nxt;

    // Held-cycle counter: runs in DOWN, frozen in REL_FLT, cleared elsewhere
    always_comb begin
        rep_cnt_nxt   = rep_cnt;
        rep_first_nxt = rep_first;
        rep_hit       = 1'b0;
        if (state == DOWN && key_p) begin
            if (rep_cnt == (rep_first ? RW'(REPEAT_DLY - 1) : RW'(REPEAT_PER - 1))) begin
                rep_hit       = 1'b1;
                rep_cnt_nxt   = '0;
                rep_first_nxt = 1'b0;
            end else begin
                rep_cnt_nxt = rep_cnt + RW'(1);
            end
        end else if (state != DOWN && state != REL_FLT) begin
            rep_cnt_nxt   = '0;
            rep_first_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else begin
            rep_cnt   <= rep_cnt_nxt;
            rep_first <= rep_first_nxt;
        end
    end
`else
    assign rep_hit = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random bouncing, every cycle checked
// against a run-length model of the debounce rules (define KEY_REPEAT_EN for repeat build).
module tb_key_debounce;

    localparam int unsigned CNT_MAX    = 8;
    localparam int unsigned REPEAT_DLY = 20;
    localparam int unsigned REPEAT_PER = 6;
    localparam logic        KEY_ACTIVE = 1'b0;
`ifdef KEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_in = 1'b1;
    logic key_flag, key_state;

    int n_assert = 0;
    int n_fail   = 0;
    logic prev_flag = 1'b0;

    key_debounce #(
        .CNT_MAX   (CNT_MAX),
        .KEY_ACTIVE(KEY_ACTIVE)
`ifdef KEY_REPEAT_EN
        ,
        .REPEAT_DLY(REPEAT_DLY),
        .REPEAT_PER(REPEAT_PER)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .key_flag (key_flag),
        .key_state(key_state)
    );

    always #5 clk = ~clk;

    // Reference: level flips after CNT_MAX+1 consecutive disagreeing synchronized samples;
    // repeats fire at held sample counts DLY, DLY+PER, ... while level and samples agree.
    logic m_s1 = 1'b1, m_s2 = 1'b1;
    logic e_lvl = 1'b0, e_flag = 1'b0;
    logic m_kp;
    int   run = 0, held = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = ~KEY_ACTIVE; m_s2 = ~KEY_ACTIVE;
            e_lvl = 1'b0; e_flag = 1'b0; run = 0; held = 0;
        end else begin
            m_kp   = (m_s2 == KEY_ACTIVE);
            e_flag = 1'b0;
            if (m_kp == e_lvl) begin
                if (REP_EN && e_lvl && run == 0) begin
                    held++;
                    if (held >= int'(REPEAT_DLY) && (held - int'(REPEAT_DLY)) % int'(REPEAT_PER) == 0)
                        e_flag = 1'b1;
                end
                run = 0;
            end else begin
                run++;
                if (run == int'(CNT_MAX) + 1) begin
                    e_lvl  = m_kp;
                    e_flag = m_kp;
                    run    = 0;
                    held   = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = key_in;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: compare both outputs with the model away from the active edge
    task automatic tick();
        @(negedge clk);
        check("key_flag", 32'(key_flag), 32'(e_flag));
        check("key_state", 32'(key_state), 32'(e_lvl));
        check("no_double_pulse", 32'(key_flag & prev_flag), 32'd0);
        prev_flag = key_flag;
    endtask

    initial begin
        int np, pidx, len;
        int pq[$];
        int eq[$];

        // 1: reset with key released
        rst = 1'b1; key_in = 1'b1;
        repeat (3) tick();
        check("t1_flag_rst", 32'(key_flag), 32'd0);
        check("t1_state_rst", 32'(key_state), 32'd0);
        rst = 1'b0;
        repeat (4) tick();
        check("t1_state_after", 32'(key_state), 32'd0);

        // 2: clean press held 30 cycles, then clean release
        key_in = 1'b0; np = 0; pidx = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (key_flag) begin np++; pidx = i; end
            if (i == 9)  check("t2_state_pre", 32'(key_state), 32'd0);
            if (i == 10) check("t2_state_on", 32'(key_state), 32'd1);
        end
        check("t2_pulses", 32'(np), 32'd1);
        check("t2_pulse_at", 32'(pidx), 32'd10);
        key_in = 1'b1; np = 0;
        for (int r = 0; r < 20; r++) begin
            tick();
            if (key_flag) np++;
            if (r == 9)  check("t2_rel_pre", 32'(key_state), 32'd1);
            if (r == 10) check("t2_rel_off", 32'(key_state), 32'd0);
        end
        check("t2_rel_pulses", 32'(np), REP_EN ? 32'd1 : 32'd0);

        // 3: bounce bursts, then steady press
        np = 0;
        for (int b = 0; b < 4; b++) begin
            key_in = 1'b0;
            repeat (5) begin tick(); if (key_flag) np++; end
            key_in = 1'b1;
            repeat (2) begin tick(); if (key_flag) np++; end
        end
        check("t3_burst_pulses", 32'(np), 32'd0);
        check("t3_burst_state", 32'(key_state), 32'd0);
        key_in = 1'b0; np = 0; pidx = -1;
        for (int i = 0; i < 26; i++) begin
            tick();
            if (key_flag) begin np++; pidx = i; end
        end
        check("t3_pulses", 32'(np), 32'd1);
        check("t3_pulse_at", 32'(pidx), 32'd10);

        // 4: reset while held 15 cycles into DOWN
        rst = 1'b1;
        tick();
        check("t4_flag_rst", 32'(key_flag), 32'd0);
        check("t4_state_rst", 32'(key_state), 32'd0);
        rst = 1'b0; np = 0; pidx = -1;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (key_flag) begin np++; pidx = j; end
        end
        check("t4_pulses", 32'(np), 32'd1);
        check("t4_pulse_at", 32'(pidx), 32'd10);
        key_in = 1'b1;
        repeat (20) tick();

        // 5: long hold, pulse positions (repeat build adds auto-repeats)
        key_in = 1'b0;
        for (int i = 0; i < 62; i++) begin
            tick();
            if (key_flag) pq.push_back(i);
        end
        key_in = 1'b1;
        repeat (20) tick();
        eq.push_back(10);
        if (REP_EN) begin
            eq.push_back(30);
            for (int k = 36; k <= 60; k += 6) eq.push_back(k);
        end
        check("t5_pulse_count", 32'(pq.size()), 32'(eq.size()));
        for (int k = 0; k < eq.size() && k < pq.size(); k++)
            check("t5_pulse_at", 32'(pq[k]), 32'(eq[k]));

        // 6: six clean presses cycle the six-mode display FSM back to WHITE
        np = 0;
        for (int p = 0; p < 6; p++) begin
            key_in = 1'b0;
            repeat (12) begin tick(); if (key_flag) np++; end
            key_in = 1'b1;
            repeat (12) begin tick(); if (key_flag) np++; end
        end
        check("t6_presses", 32'(np), 32'd6);
        check("t6_mode_white", 32'(np % 6), 32'd0);

        // Random bouncing with one mid-run reset
        for (int s = 0; s < 60; s++) begin
            key_in = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 14));
            if (s == 30) rst = 1'b1;
            repeat (len) begin tick(); rst = 1'b0; end
        end
        key_in = 1'b1;
        repeat (20) tick();
        check("final_state", 32'(key_state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
